// File: rtl/clause_mem_loader.sv
// Packs a streamed CNF formula, one literal per beat, into {type, mask, size}
// clause words and writes them sequentially into the BCP clause memory.
//   state   | meaning
//   IDLE    | waiting for load_start
//   COLLECT | accepting literals of the current clause
//   WRITE   | one-cycle clause commit (mem_we high when the clause is kept)
//   FULL    | memory holds DEPTH clauses, literals stall
//   DONE    | load_done pulse, then back to IDLE
module clause_mem_loader #(
    parameter int ADDR_W = 3,
    parameter int NVAR   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              lit_valid,
    output logic              lit_ready,
    input  logic [2:0]        lit_var,
    input  logic              lit_neg,
    input  logic              lit_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    output logic [ADDR_W:0]   clause_count,
    output logic              load_done,
    output logic              mem_full,
    output logic              taut_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        FULL,
        DONE
    } state_t;

    state_t            state;
    logic [NVAR-1:0]   mask;
    logic [NVAR-1:0]   type_bits;
    logic              taut;
    logic              end_pend;
    logic [ADDR_W-1:0] address;

    logic              accept;
    logic              finish;
    logic [NVAR-1:0]   mask_nxt;
    logic [NVAR-1:0]   type_nxt;
    logic              taut_nxt;
    logic [ADDR_W:0]   count_nxt;

    function automatic logic [7:0] popcount(input logic [NVAR-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < NVAR; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

    // Clause contents including the literal accepted this cycle, so the
    // clause word can be registered on the same edge that enters WRITE.
    always_comb begin
        accept   = (state == COLLECT) && lit_valid && lit_ready;
        finish   = load_end || end_pend;
        mask_nxt = mask;
        type_nxt = type_bits;
        taut_nxt = taut;
        if (accept) begin
            if (mask[lit_var] && (type_bits[lit_var] != lit_neg)) begin
                taut_nxt = 1'b1;
            end
            mask_nxt[lit_var] = 1'b1;
            type_nxt[lit_var] = lit_neg;
        end
        count_nxt = clause_count + (ADDR_W + 1)'(mem_we);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mask         <= '0;
            type_bits    <= '0;
            taut         <= 1'b0;
            end_pend     <= 1'b0;
            address      <= '0;
            lit_ready    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            clause_count <= '0;
            load_done    <= 1'b0;
            mem_full     <= 1'b0;
            taut_drop    <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            if (load_start && state != DONE) begin
                state        <= COLLECT;
                lit_ready    <= 1'b1;
                mask         <= '0;
                type_bits    <= '0;
                taut         <= 1'b0;
                end_pend     <= 1'b0;
                address      <= '0;
                clause_count <= '0;
                mem_full     <= 1'b0;
                taut_drop    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        lit_ready <= 1'b0;
                    end
                    COLLECT: begin
                        mask      <= mask_nxt;
                        type_bits <= type_nxt;
                        taut      <= taut_nxt;
                        if ((accept && (lit_last || finish)) ||
                            (!accept && finish && mask != '0)) begin
                            state     <= WRITE;
                            lit_ready <= 1'b0;
                            end_pend  <= finish;
                            mem_we    <= !taut_nxt && (mask_nxt != '0);
                            mem_addr  <= address;
                            mem_wdata <= {type_nxt, mask_nxt, popcount(mask_nxt)};
                        end else if (finish) begin
                            state     <= DONE;
                            lit_ready <= 1'b0;
                            load_done <= 1'b1;
                            end_pend  <= 1'b0;
                        end
                    end
                    WRITE: begin
                        mask      <= '0;
                        type_bits <= '0;
                        taut      <= 1'b0;
                        if (mem_we) begin
                            address      <= address + 1'b1;
                            clause_count <= count_nxt;
                        end
                        if (taut) begin
                            taut_drop <= 1'b1;
                        end
                        if (count_nxt == (ADDR_W + 1)'(DEPTH)) begin
                            state    <= FULL;
                            mem_full <= 1'b1;
                        end else if (end_pend || load_end) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            end_pend  <= 1'b0;
                        end else begin
                            state     <= COLLECT;
                            lit_ready <= 1'b1;
                        end
                    end
                    FULL: begin
                        lit_ready <= 1'b0;
                        if (load_end || end_pend) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            end_pend  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        lit_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clause_mem_loader.sv
// Directed bench for clause_mem_loader: clause packing, tautology drop,
// memory-full stall, partial-clause flush, abort and mid-load reset.
module tb_clause_mem_loader;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic        load_end;
    logic        lit_valid;
    logic        lit_ready;
    logic [2:0]  lit_var;
    logic        lit_neg;
    logic        lit_last;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic [3:0]  clause_count;
    logic        load_done;
    logic        mem_full;
    logic        taut_drop;

    clause_mem_loader #(.ADDR_W(3), .NVAR(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .load_end     (load_end),
        .lit_valid    (lit_valid),
        .lit_ready    (lit_ready),
        .lit_var      (lit_var),
        .lit_neg      (lit_neg),
        .lit_last     (lit_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .clause_count (clause_count),
        .load_done    (load_done),
        .mem_full     (mem_full),
        .taut_drop    (taut_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  addr;
        logic [23:0] data;
        int          cyc;
    } wr_t;

    wr_t wlog[$];
    int  dlog[$];
    int  cyc = 0;
    int  last_cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we) wlog.push_back('{mem_addr, mem_wdata, cyc});
        if (load_done) dlog.push_back(cyc);
    end

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
    endtask

    task automatic do_start();
        @(negedge clock);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    // Presents one beat; a last beat is followed by one idle (WRITE) cycle.
    task automatic beat(input int v, input bit n, input bit last);
        @(negedge clock);
        lit_valid = 1'b1;
        lit_var   = 3'(v);
        lit_neg   = n;
        lit_last  = last;
        last_cyc  = cyc;
        if (last) begin
            @(negedge clock);
            lit_valid = 1'b0;
            lit_last  = 1'b0;
        end
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        @(negedge clock);
        load_end = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && dlog.size() == 0; i++) begin
            @(negedge clock);
            #1;
        end
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({lit_ready, mem_we, mem_addr, mem_wdata, clause_count, load_done, mem_full, taut_drop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d wdata=%h cnt=%0d done=%b full=%b taut=%b, required all 0",
                     lit_ready, mem_we, mem_addr, mem_wdata, clause_count, load_done, mem_full, taut_drop);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        n_cmp++;
        if (lit_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: got %b required 0", lit_ready);
        end
    endtask

    task automatic test_single_clause();
        int n;
        clear_logs();
        do_start();
        beat(0, 0, 0);
        beat(2, 1, 0);
        beat(5, 0, 1);
        n = last_cyc;
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1) begin
            n_err++;
            $display("FAIL single_writes: got %0d required 1", wlog.size());
        end else begin
            n_cmp++;
            if (wlog[0].addr !== 3'd0 || wlog[0].data !== 24'h042503) begin
                n_err++;
                $display("FAIL single_word: got addr %0d data %h required addr 0 data 042503", wlog[0].addr, wlog[0].data);
            end
            n_cmp++;
            if (wlog[0].cyc !== n + 1) begin
                n_err++;
                $display("FAIL single_we_latency: got cycle %0d required %0d", wlog[0].cyc, n + 1);
            end
        end
        n_cmp++;
        if (dlog.size() !== 1 || dlog[0] !== n + 2) begin
            n_err++;
            $display("FAIL single_done: got %0d pulses first at %0d required 1 pulse at %0d",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] : -1, n + 2);
        end
        n_cmp++;
        if (clause_count !== 4'd1 || taut_drop !== 1'b0 || mem_full !== 1'b0) begin
            n_err++;
            $display("FAIL single_status: got cnt=%0d taut=%b full=%b required cnt=1 taut=0 full=0", clause_count, taut_drop, mem_full);
        end
    endtask

    task automatic test_duplicate();
        clear_logs();
        do_start();
        beat(1, 0, 0);
        beat(1, 0, 0);
        beat(3, 1, 1);
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].data !== 24'h080A02) begin
            n_err++;
            $display("FAIL duplicate_word: got %0d writes data %h required 1 write 080a02",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].data : 24'h0);
        end
        n_cmp++;
        if (taut_drop !== 1'b0 || clause_count !== 4'd1) begin
            n_err++;
            $display("FAIL duplicate_status: got taut=%b cnt=%0d required taut=0 cnt=1", taut_drop, clause_count);
        end
    endtask

    task automatic test_tautology();
        clear_logs();
        do_start();
        beat(4, 0, 0);
        beat(4, 1, 0);
        beat(6, 0, 1);
        beat(7, 0, 1);
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].addr !== 3'd0 || wlog[0].data !== 24'h008001) begin
            n_err++;
            $display("FAIL taut_word: got %0d writes addr %0d data %h required 1 write addr 0 data 008001",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].addr : 3'd0, (wlog.size() > 0) ? wlog[0].data : 24'h0);
        end
        n_cmp++;
        if (taut_drop !== 1'b1 || clause_count !== 4'd1) begin
            n_err++;
            $display("FAIL taut_status: got taut=%b cnt=%0d required taut=1 cnt=1", taut_drop, clause_count);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        do_start();
        beat(0, 0, 0);
        beat(1, 0, 1);
        beat(7, 1, 1);
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 2) begin
            n_err++;
            $display("FAIL b2b_writes: got %0d required 2", wlog.size());
        end else begin
            n_cmp++;
            if (wlog[0].addr !== 3'd0 || wlog[0].data !== 24'h000302 ||
                wlog[1].addr !== 3'd1 || wlog[1].data !== 24'h808001) begin
                n_err++;
                $display("FAIL b2b_words: got %0d:%h %0d:%h required 0:000302 1:808001",
                         wlog[0].addr, wlog[0].data, wlog[1].addr, wlog[1].data);
            end
        end
        n_cmp++;
        if (clause_count !== 4'd2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d required 2", clause_count);
        end
    endtask

    task automatic test_full();
        logic [23:0] exp;
        clear_logs();
        do_start();
        for (int i = 0; i < 8; i++) beat(i, 0, 1);
        beat(3, 1, 0);
        #1;
        n_cmp++;
        if (lit_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b required 0", lit_ready);
        end
        repeat (3) @(negedge clock);
        lit_valid = 1'b0;
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 8) begin
            n_err++;
            $display("FAIL full_writes: got %0d required 8", wlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp = {8'h00, 8'(1 << i), 8'h01};
                n_cmp++;
                if (wlog[i].addr !== 3'(i) || wlog[i].data !== exp) begin
                    n_err++;
                    $display("FAIL full_word%0d: got addr %0d data %h required addr %0d data %h",
                             i, wlog[i].addr, wlog[i].data, i, exp);
                end
            end
        end
        n_cmp++;
        if (mem_full !== 1'b1 || clause_count !== 4'd8 || dlog.size() !== 1) begin
            n_err++;
            $display("FAIL full_status: got full=%b cnt=%0d done_pulses=%0d required full=1 cnt=8 done_pulses=1",
                     mem_full, clause_count, dlog.size());
        end
    endtask

    task automatic test_partial_flush();
        clear_logs();
        do_start();
        beat(0, 1, 0);
        beat(1, 0, 0);
        @(negedge clock);
        lit_valid = 1'b0;
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].data !== 24'h010302 || dlog.size() !== 1) begin
            n_err++;
            $display("FAIL partial_flush: got %0d writes data %h done_pulses %0d required 1 write 010302 done_pulses 1",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].data : 24'h0, dlog.size());
        end
        n_cmp++;
        if (mem_full !== 1'b0 || clause_count !== 4'd1) begin
            n_err++;
            $display("FAIL partial_status: got full=%b cnt=%0d required full=0 cnt=1", mem_full, clause_count);
        end
    endtask

    task automatic test_end_with_beat();
        clear_logs();
        do_start();
        beat(6, 1, 0);
        load_end = 1'b1;
        @(negedge clock);
        lit_valid = 1'b0;
        load_end  = 1'b0;
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].data !== 24'h404001 || dlog.size() !== 1) begin
            n_err++;
            $display("FAIL end_with_beat: got %0d writes data %h done_pulses %0d required 1 write 404001 done_pulses 1",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].data : 24'h0, dlog.size());
        end
    endtask

    task automatic test_abort();
        clear_logs();
        do_start();
        beat(3, 0, 0);
        @(negedge clock);
        lit_valid = 1'b0;
        do_start();
        beat(5, 0, 1);
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].addr !== 3'd0 || wlog[0].data !== 24'h002001) begin
            n_err++;
            $display("FAIL abort_word: got %0d writes addr %0d data %h required 1 write addr 0 data 002001",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].addr : 3'd0, (wlog.size() > 0) ? wlog[0].data : 24'h0);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        do_start();
        beat(0, 0, 0);
        beat(1, 0, 0);
        @(negedge clock);
        lit_valid = 1'b0;
        reset     = 1'b0;
        #1;
        n_cmp++;
        if ({lit_ready, mem_we, clause_count, load_done, mem_full, taut_drop} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got ready=%b we=%b cnt=%0d done=%b full=%b taut=%b required all 0",
                     lit_ready, mem_we, clause_count, load_done, mem_full, taut_drop);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++;
        if (wlog.size() !== 0) begin
            n_err++;
            $display("FAIL midreset_nowrite: got %0d writes required 0", wlog.size());
        end
        do_start();
        beat(2, 0, 1);
        pulse_end();
        wait_done();
        n_cmp++;
        if (wlog.size() !== 1 || wlog[0].addr !== 3'd0 || wlog[0].data !== 24'h000401) begin
            n_err++;
            $display("FAIL midreset_reload: got %0d writes addr %0d data %h required 1 write addr 0 data 000401",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].addr : 3'd0, (wlog.size() > 0) ? wlog[0].data : 24'h0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
        lit_valid  = 1'b0;
        lit_var    = 3'd0;
        lit_neg    = 1'b0;
        lit_last   = 1'b0;
        test_reset();
        test_single_clause();
        test_duplicate();
        test_tautology();
        test_back_to_back();
        test_full();
        test_partial_flush();
        test_end_with_beat();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clause_mem_loader.md
Name: clause_mem_loader

Overview:
- Upstream stage of the BCP initialisation controller.
- Accepts a streamed CNF formula one literal per beat and packs each clause into a 24-bit clause word {type[23:16], mask[15:8], size[7:0]}.
- Writes each word sequentially into the clause memory that the BCP initialisation controller later reads.
- Pulses a completion strobe; this strobe drives that controller's system_initial_signal.

Parameters:
- ADDR_W, 3, clause memory address width; memory depth DEPTH = 2**ADDR_W.
- NVAR, 8, variables per clause window; equals bcp_check_num; fixes type/mask width at 8.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse: begin new formula load
- load_end  in  1  level/pulse: formula stream finished
- lit_valid  in  1  literal beat valid
- lit_ready  out  1  loader can accept a literal
- lit_var  in  3  variable index 0..7
- lit_neg  in  1  1 = negated literal
- lit_last  in  1  last literal of current clause
- mem_we  out  1  clause memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  24  {type, mask, size}
- clause_count  out  ADDR_W+1  clauses written in current load
- load_done  out  1  one-cycle completion pulse
- mem_full  out  1  sticky: DEPTH clauses written
- taut_drop  out  1  sticky: at least one tautological clause discarded

Behaviour:
- Reset values: all outputs 0; internal mask/type/address cleared; state IDLE.
- States: IDLE, COLLECT, WRITE, FULL, DONE.
- IDLE:
  - lit_ready = 0.
  - load_start -> COLLECT; clears clause_count, address, mem_full, taut_drop.
- COLLECT:
  - lit_ready = 1.
  - On lit_valid & lit_ready: mask[lit_var] <= 1; type[lit_var] <= lit_neg.
  - If mask[lit_var] was already 1 with the opposite polarity, the clause is marked tautological.
  - A duplicate literal with the same polarity is idempotent.
  - If lit_last is set on the accepted beat -> WRITE.
- WRITE: one cycle, lit_ready = 0.
  - Non-tautological and mask != 0: mem_we = 1, mem_addr = address, mem_wdata = {type, mask, popcount(mask)}; address and clause_count increment.
  - Tautological: no write; taut_drop <= 1.
  - Empty mask (cannot occur in normal streams) is also not written.
  - Mask, type and the tautology mark clear.
  - Next state: if clause_count reaches DEPTH -> FULL (mem_full <= 1); else if load_end is pending -> DONE; else -> COLLECT.
- load_end in COLLECT:
  - No partial clause (mask == 0): -> DONE.
  - Partial clause: the clause is flushed through WRITE as if lit_last had arrived, then -> DONE.
  - load_end arriving together with an accepted beat: the beat is consumed first, then the clause is flushed.
- FULL:
  - lit_ready = 0; incoming literals stall.
  - load_end -> DONE. load_start -> COLLECT with counters cleared.
- DONE: load_done = 1 for exactly one cycle -> IDLE. clause_count holds its value until the next load_start.
- Latency: last literal accepted at cycle N -> mem_we at N+1 -> earliest load_done at N+2.
- Address never wraps; max clause_count = DEPTH.
- load_start in COLLECT/WRITE aborts the current load: the partial clause is discarded, counters clear, state = COLLECT.
- Reset mid-operation: immediate return to IDLE, no write issued.
- Type bits of variables absent from the mask are 0.

Test Plan:
- Single clause (x0 ∨ ¬x2 ∨ x5), lit_last on x5, then load_end -> one write, addr 0, wdata = 0x04_25_03, load_done 2 cycles after the last beat, clause_count = 1.
- Clause with duplicate literal (x1, x1, ¬x3) -> wdata = 0x08_0A_02.
- Tautological clause (x4, ¬x4, x6) then valid clause (x7) -> single write at addr 0 = 0x00_80_01; taut_drop = 1; clause_count = 1.
- Nine single-literal clauses with DEPTH = 8 -> 8 writes at addr 0..7; mem_full = 1; lit_ready = 0 on the 9th beat; load_end -> load_done; clause_count = 8.
- Partial clause (¬x0, x1) with no lit_last, then load_end -> write 0x01_03_02, then load_done.
- Reset asserted in COLLECT after 2 literals -> no mem_we; all outputs 0; a subsequent load_start then clause (x2) -> write at addr 0.
